// File: rtl/matrix_result_streamer.sv
// ---------------------------------------------------------------------------
// matrix_result_streamer
//
// Purpose:
//   Consumer end of the systolic matrix multiplier's start/done/result_c
//   interface. When the multiplier pulses done_in, the whole packed result
//   bus is copied into a local buffer. The buffer is then streamed out one
//   element per beat, in row-major order, over a valid/ready interface.
//   Each beat carries the element's row/column and a last-element flag.
//
// Parameters:
//   RESULT_WIDTH  width of one two's complement result element
//   M             rows of result matrix C
//   P             columns of result matrix C
//
// Ports:
//   clk          single rising-edge clock
//   rst          asynchronous, active-low reset
//   done_in      one-cycle pulse; result_c is valid in that cycle
//   result_c     packed results, C[i][j] at [(i*P+j)*RESULT_WIDTH +: RESULT_WIDTH]
//   out_data     current element (registered)
//   out_valid    out_data/out_row/out_col/out_last are valid
//   out_ready    consumer accepts the beat when out_valid && out_ready
//   out_row      row index of the current element
//   out_col      column index of the current element
//   out_last     high on the final element of a frame
//   busy         high while a frame is buffered or streaming
//   overrun      sticky flag; a done_in pulse arrived mid-frame and was dropped
//   frame_count  frames fully streamed, wraps 255 -> 0
// ---------------------------------------------------------------------------
module matrix_result_streamer #(
  parameter int RESULT_WIDTH = 16,
  parameter int M            = 8,
  parameter int P            = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 done_in,
  input  logic [M*P*RESULT_WIDTH-1:0]          result_c,
  output logic [RESULT_WIDTH-1:0]              out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] out_row,
  output logic [((P > 1) ? $clog2(P) : 1)-1:0] out_col,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 overrun,
  output logic [7:0]                           frame_count
);

  localparam int N     = M * P;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
  localparam int COL_W = (P > 1) ? $clog2(P) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(P - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t state;
  state_t next_state;

  logic [RESULT_WIDTH-1:0] buffer [N];
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_next;

  logic handshake;
  logic at_last;
  logic capture;
  logic advance;
  logic frame_done;
  logic drop;

  assign handshake = out_valid && out_ready;
  assign at_last   = (idx == LAST_IDX);
  assign idx_next  = idx + 1'b1;

  // State register for the capture/stream controller.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode.
  // A done_in pulse is only honoured when the buffer is free: either in IDLE,
  // or on the very handshake that retires the last element of the current
  // frame (back-to-back capture with no bubble). Any other done_in while
  // streaming would clobber a frame that is still being read, so it is
  // dropped and flagged instead.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    advance    = 1'b0;
    frame_done = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (done_in) begin
          capture    = 1'b1;
          next_state = STREAM;
        end
      end
      STREAM: begin
        if (handshake && at_last) begin
          frame_done = 1'b1;
          if (done_in) begin
            capture = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end else begin
          if (handshake) begin
            advance = 1'b1;
          end
          if (done_in) begin
            drop = 1'b1;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Frame buffer. Its contents are don't-care after reset, so it carries no
  // reset and is written only in a capture cycle; result_c is ignored at all
  // other times.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < N; k++) begin
        buffer[k] <= result_c[k*RESULT_WIDTH +: RESULT_WIDTH];
      end
    end
  end

  // Registered output beat.
  // Element 0 is taken straight from result_c on capture because the buffer
  // only holds the new frame from the following cycle. Row and column are
  // tracked as a wrapping counter pair rather than derived by divide/modulo.
  // When neither capture nor advance fires (for example a stall), every beat
  // register holds, so a stalled beat never changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (capture) begin
        idx       <= '0;
        out_data  <= result_c[RESULT_WIDTH-1:0];
        out_row   <= '0;
        out_col   <= '0;
        out_last  <= (N == 1);
        out_valid <= 1'b1;
        busy      <= 1'b1;
      end else if (advance) begin
        idx      <= idx_next;
        out_data <= buffer[idx_next];
        out_last <= (idx_next == LAST_IDX);
        if (out_col == LAST_COL) begin
          out_col <= '0;
          out_row <= out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end else if (frame_done) begin
        out_valid <= 1'b0;
        busy      <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Frame counter and sticky overrun flag. A frame counts only once its last
  // element has been accepted, so a reset mid-frame never bumps the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      if (frame_done) begin
        frame_count <= frame_count + 8'd1;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// ---------------------------------------------------------------------------
// tb_matrix_result_streamer
//
// Directed bench for matrix_result_streamer with M = P = 8, RESULT_WIDTH = 16.
// Expected frames are built in exp_mem by the bench, and every beat is
// compared against exp_mem plus the row/column/last values computed from the
// beat number.
// ---------------------------------------------------------------------------
module tb_matrix_result_streamer;

  localparam int W  = 16;
  localparam int M  = 8;
  localparam int P  = 8;
  localparam int N  = M * P;
  localparam int FW = N * W;

  logic          clk;
  logic          rst;
  logic          done_in;
  logic [FW-1:0] result_c;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_row;
  logic [2:0]    out_col;
  logic          out_last;
  logic          busy;
  logic          overrun;
  logic [7:0]    frame_count;

  int compared;
  int mismatched;

  logic [W-1:0]  exp_mem [N];
  logic [FW-1:0] alt_frame;

  matrix_result_streamer #(
    .RESULT_WIDTH(W),
    .M(M),
    .P(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .done_in(done_in),
    .result_c(result_c),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row(out_row),
    .out_col(out_col),
    .out_last(out_last),
    .busy(busy),
    .overrun(overrun),
    .frame_count(frame_count)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 time unit after the next rising edge. All stimulus is
  // driven and all outputs are sampled at that point.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [FW-1:0] packFrame();
    logic [FW-1:0] f;
    for (int k = 0; k < N; k++) begin
      f[k*W +: W] = exp_mem[k];
    end
    return f;
  endfunction

  // Present a frame on result_c together with a one-cycle done_in pulse.
  task automatic applyStimulus(input logic [FW-1:0] frame);
    result_c = frame;
    done_in  = 1'b1;
    stepClock();
    done_in  = 1'b0;
  endtask

  // Consume nbeats beats of the frame held in exp_mem, checking every cycle
  // (stalled or not) against the beat currently expected.
  // stall_mode 0: out_ready held high; 1: out_ready pattern 1,0,0,1,0,0,...
  // inject_at >= 0: pulse done_in with alt_frame on the cycle beat
  // inject_at is presented.
  task automatic runFrame(input string tag, input int stall_mode,
                          input int nbeats, input int inject_at);
    int  b;
    int  c;
    logic rdy;
    b = 0;
    c = 0;
    while (b < nbeats && c < 1000) begin
      checkOutput($sformatf("%s valid b%0d", tag, b), 32'(out_valid), 32'd1);
      checkOutput($sformatf("%s data b%0d", tag, b), 32'(out_data), 32'(exp_mem[b]));
      checkOutput($sformatf("%s row b%0d", tag, b), 32'(out_row), 32'(b / P));
      checkOutput($sformatf("%s col b%0d", tag, b), 32'(out_col), 32'(b % P));
      checkOutput($sformatf("%s last b%0d", tag, b), 32'(out_last), 32'(b == N - 1));
      rdy = (stall_mode == 0) ? 1'b1 : ((c % 3) == 0);
      out_ready = rdy;
      if (b == inject_at) begin
        result_c = alt_frame;
        done_in  = 1'b1;
      end
      stepClock();
      done_in = 1'b0;
      if (rdy) begin
        b++;
      end
      c++;
    end
    checkOutput($sformatf("%s beats", tag), 32'(b), 32'(nbeats));
  endtask

  // Hold reset for one clock, checking the asynchronous clear first.
  task automatic applyReset(input string tag);
    rst = 1'b0;
    #2;
    checkOutput($sformatf("%s valid", tag), 32'(out_valid), 32'd0);
    checkOutput($sformatf("%s busy", tag), 32'(busy), 32'd0);
    checkOutput($sformatf("%s last", tag), 32'(out_last), 32'd0);
    checkOutput($sformatf("%s overrun", tag), 32'(overrun), 32'd0);
    checkOutput($sformatf("%s frame_count", tag), 32'(frame_count), 32'd0);
    stepClock();
    rst = 1'b1;
    stepClock();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    done_in    = 1'b0;
    out_ready  = 1'b1;
    result_c   = '0;
    alt_frame  = '0;
    #2;

    // Reset state.
    applyReset("reset");
    checkOutput("reset data", 32'(out_data), 32'd0);
    checkOutput("reset row", 32'(out_row), 32'd0);
    checkOutput("reset col", 32'(out_col), 32'd0);

    // 1: identity frame, no backpressure.
    $display("[TB] identity frame");
    for (int k = 0; k < N; k++) exp_mem[k] = 16'(k);
    applyStimulus(packFrame());
    checkOutput("t1 busy", 32'(busy), 32'd1);
    runFrame("t1", 0, N, -1);
    checkOutput("t1 valid after", 32'(out_valid), 32'd0);
    checkOutput("t1 busy after", 32'(busy), 32'd0);
    checkOutput("t1 frame_count", 32'(frame_count), 32'd1);

    // 2: backpressure with negative values.
    $display("[TB] backpressure frame");
    for (int k = 0; k < N; k++) exp_mem[k] = 16'h8000 + 16'(k);
    applyStimulus(packFrame());
    runFrame("t2", 1, N, -1);
    checkOutput("t2 valid after", 32'(out_valid), 32'd0);
    checkOutput("t2 frame_count", 32'(frame_count), 32'd2);
    checkOutput("t2 overrun", 32'(overrun), 32'd0);

    // 3: done_in mid-frame is dropped and flagged.
    $display("[TB] overrun frame");
    for (int k = 0; k < N; k++) exp_mem[k] = 16'h0300 + 16'(k);
    for (int k = 0; k < N; k++) alt_frame[k*W +: W] = 16'hDEAD;
    applyStimulus(packFrame());
    runFrame("t3", 0, N, 10);
    checkOutput("t3 valid after", 32'(out_valid), 32'd0);
    checkOutput("t3 overrun", 32'(overrun), 32'd1);
    checkOutput("t3 frame_count", 32'(frame_count), 32'd3);
    stepClock();
    stepClock();
    checkOutput("t3 no second frame", 32'(out_valid), 32'd0);
    checkOutput("t3 overrun sticky", 32'(overrun), 32'd1);

    applyReset("reset2");

    // 4: back-to-back capture on the final handshake.
    $display("[TB] back-to-back frames");
    for (int k = 0; k < N; k++) exp_mem[k] = 16'h1111;
    for (int k = 0; k < N; k++) alt_frame[k*W +: W] = 16'h2222;
    applyStimulus(packFrame());
    runFrame("t4a", 0, N, N - 1);
    checkOutput("t4 no bubble valid", 32'(out_valid), 32'd1);
    checkOutput("t4 busy", 32'(busy), 32'd1);
    checkOutput("t4 frame_count mid", 32'(frame_count), 32'd1);
    for (int k = 0; k < N; k++) exp_mem[k] = 16'h2222;
    runFrame("t4b", 0, N, -1);
    checkOutput("t4 valid after", 32'(out_valid), 32'd0);
    checkOutput("t4 overrun", 32'(overrun), 32'd0);
    checkOutput("t4 frame_count", 32'(frame_count), 32'd2);

    // 5: asynchronous reset mid-stream.
    $display("[TB] reset mid-stream");
    for (int k = 0; k < N; k++) exp_mem[k] = 16'h5000 + 16'(k);
    applyStimulus(packFrame());
    runFrame("t5a", 0, 21, -1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t5 async valid", 32'(out_valid), 32'd0);
    checkOutput("t5 async busy", 32'(busy), 32'd0);
    checkOutput("t5 async last", 32'(out_last), 32'd0);
    checkOutput("t5 async frame_count", 32'(frame_count), 32'd0);
    stepClock();
    rst = 1'b1;
    stepClock();
    checkOutput("t5 no more beats", 32'(out_valid), 32'd0);
    for (int k = 0; k < N; k++) exp_mem[k] = 16'(k);
    applyStimulus(packFrame());
    runFrame("t5b", 0, N, -1);
    checkOutput("t5 frame_count", 32'(frame_count), 32'd1);

    // 6: frame_count wrap.
    $display("[TB] frame_count wrap");
    applyReset("reset3");
    for (int f = 1; f <= 257; f++) begin
      applyStimulus(packFrame());
      runFrame("t6", 0, N, -1);
      if (f == 255) checkOutput("t6 count 255", 32'(frame_count), 32'd255);
      if (f == 256) checkOutput("t6 count wrap", 32'(frame_count), 32'd0);
      if (f == 257) checkOutput("t6 count after wrap", 32'(frame_count), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
- Drains the packed result bus of the systolic matrix multiplier.
- On the multiplier's done pulse it captures all M*P results into a local buffer. It then streams them out one element per beat, in row-major order, over a valid/ready interface.
- Sits between the multiplier output and downstream consumers such as a memory writer or host FIFO. It is the consumer end of the multiplier's start/done/result_c interface.

Parameters:
- RESULT_WIDTH, 16, width of one result element (two's complement).
- M, 8, rows of result matrix C.
- P, 8, columns of result matrix C.

Ports:
- clk  input  1  single clock; all logic is rising-edge triggered.
- rst  input  1  asynchronous, active-low reset.
- done_in  input  1  one-cycle pulse from the multiplier; result_c is valid in that cycle.
- result_c  input  M*P*RESULT_WIDTH  packed results; element C[i][j] is at bits [(i*P+j)*RESULT_WIDTH +: RESULT_WIDTH].
- out_data  output  RESULT_WIDTH  current element.
- out_valid  output  1  out_data/out_row/out_col/out_last are valid.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
- out_row  output  $clog2(M) (min 1)  row index i of the current element.
- out_col  output  $clog2(P) (min 1)  column index j of the current element.
- out_last  output  1  high on the element at index M*P-1.
- busy  output  1  high while a frame is buffered or streaming.
- overrun  output  1  sticky; a done_in pulse was dropped.
- frame_count  output  8  frames fully streamed; wraps 255->0.

Behaviour:
Reset (rst=0, asynchronous):
- State goes to IDLE.
- out_valid, out_last, busy and overrun go to 0.
- out_data, out_row, out_col and frame_count go to 0.
- Buffer contents are don't-care.
- Reset mid-stream abandons the frame: no further beats, and frame_count is not incremented.

IDLE:
- out_valid=0, busy=0.
- On done_in=1: register the whole result_c into the buffer, set idx=0, and go to STREAM.
- busy=1 and out_valid=1 from the next cycle. Latency from done_in to the first valid beat is 1 cycle.

STREAM:
- out_data = buffer[idx]; out_row = idx/P; out_col = idx%P; out_last = (idx==M*P-1).
- All of these are registered outputs.
- While out_valid && !out_ready, all outputs hold stable. No beat may change or drop while stalled.
- On a handshake with idx<M*P-1: idx increments, and the next element is presented in the following cycle. With out_ready held high, throughput is 1 element per cycle.
- On a handshake with idx==M*P-1:
  - frame_count increments (modulo 256).
  - If done_in is not high in that same cycle: go to IDLE, and out_valid=0, busy=0 next cycle.
  - If done_in is high in that same cycle: this is a back-to-back capture. Capture the new result_c, set idx=0, stay in STREAM, and present new element 0 next cycle with no bubble. overrun is not set.
- done_in=1 in STREAM on any other cycle is ignored. The buffer is not overwritten and overrun is set to 1. overrun stays set until reset.

Data rules:
- Elements are passed bit-exact. No sign extension, saturation or reordering.
- A frame is exactly M*P beats, and out_last is asserted on exactly one beat per frame.
- result_c is sampled only in a capture cycle; changes at any other time have no effect.

Test Plan:
1. Identity capture, M=P=8: result_c[k] = k for k=0..63, one done_in pulse, out_ready held 1 -> 64 consecutive beats with out_data 0..63. (row,col) runs (0,0)..(7,7). out_last only on data 63. out_valid falls the cycle after. frame_count=1.
2. Backpressure: result_c[k] = 16'h8000 + k; out_ready toggles 1,0,0,1,... -> out_data holds stable through every stall. The sequence is 16'h8000..16'h803F with no beat lost or duplicated. Negative values stay bit-exact.
3. Overrun: done_in pulsed again at beat 10 of frame 1, with a different result_c -> frame 1 data is unaffected and overrun=1. No second frame follows. overrun stays 1 after the frame completes.
4. Back-to-back: frame 1 all 16'h1111, frame 2 all 16'h2222, second done_in coincident with the final handshake -> beat 64 = 16'h1111 (last), beat 65 = 16'h2222 with no idle cycle. overrun=0 and frame_count=2.
5. Reset mid-stream: rst driven to 0 asynchronously after beat 20 (between clock edges) -> out_valid, busy and out_last go to 0 immediately, and frame_count=0. A new done_in after release restarts at element 0 (0,0).
6. frame_count wrap: 256 frames streamed -> frame_count reads 0 after the 256th out_last handshake and 1 after the 257th.
